vga_sequencer_ctrl: RTL and testbench
=====================================

Name: vga_sequencer_ctrl

Overview:
Host-facing controller for the VGA timing sequencer. It holds a microcode image written by software, and stops the sequencer cleanly at a frame boundary. It then streams the image into the sequencer's instruction memory, one word per clock, and re-enables scan-out. It also exposes run control, status and a frame counter on the peripheral register bus.

Parameters:
MAX_INSTRUCTIONS, 48, depth of staging buffer; must equal sequencer program depth.
UOP_WIDTH, 18, valid low bits of each program word.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
io_write_en  in  1  register write strobe
io_read_en  in  1  register read strobe
io_address  in  4  register word index
io_write_data  in  32  register write data
io_read_data  out  32  register read data, 1-cycle latency
start_frame  in  1  from sequencer: high while its PC is 0 and it is enabled
sequencer_en  out  1  run enable to sequencer
prog_write_en  out  1  program-word write strobe to sequencer
prog_data  out  32  program word; bits above UOP_WIDTH are zero
frame_irq  out  1  one-cycle pulse per frame start

Behaviour:
- Registers (io_address):
  - 0 CTRL, R/W: bit0 run_req.
  - 1 PROG_DATA, W: push word into staging buffer.
  - 2 COMMIT, W: any write requests an upload.
  - 3 STATUS, R: bit0 busy (state != IDLE/RUNNING); bit1 overflow (sticky); bit2 sequencer_en; bit3 commit_pending; [13:8] staged_count.
  - 4 FRAME_COUNT, R.
  - Write to STATUS clears overflow. Other addresses read 0; writes to them are ignored.
- Reset values: every output is 0. All registers and counters are 0, dirty=0, state=IDLE.
- Staging buffer:
  - sram_1r1w, MAX_INSTRUCTIONS x UOP_WIDTH, 1-cycle read latency.
  - PROG_DATA push writes at index staged_count, then staged_count++.
  - If staged_count==MAX_INSTRUCTIONS, the push is dropped and overflow is set.
  - In LOAD, DRAIN or SYNC, a push is dropped and overflow is set; the buffer is unchanged.
- FSM states: IDLE, RUNNING, DRAIN, SYNC, LOAD.
  - IDLE: sequencer_en=0.
    - COMMIT with staged_count>0: go to SYNC if dirty, else LOAD.
    - Else run_req=1: go to RUNNING.
    - COMMIT with staged_count==0 is ignored.
  - RUNNING: sequencer_en=1; clears dirty.
    - COMMIT (staged_count>0) sets commit_pending and goes to DRAIN.
    - run_req=0: go to IDLE on the first start_frame rising edge, so a frame is never truncated.
  - DRAIN: sequencer_en stays 1 until start_frame rising edge is seen, then go to LOAD; sequencer_en=0 from the next cycle.
  - SYNC: sequencer_en=1 for exactly one cycle. This rezeroes the sequencer's load pointer. The resulting one-cycle sync glitch is accepted. Then go to LOAD.
  - LOAD:
    - Issue buffer read address k on cycle k. prog_write_en=1 with word k on cycle k+1, for k=0..staged_count-1, contiguous, sequencer_en=0 throughout.
    - After the last word: staged_count:=0, commit_pending:=0.
    - Then go to RUNNING if run_req=1, else IDLE with dirty:=1.
    - Total load latency: staged_count+1 cycles.
- run_req changes during DRAIN/SYNC/LOAD are registered but only sampled at LOAD exit.
- A second COMMIT while commit_pending is ignored.
- start_frame edge detect uses a registered copy of start_frame. An edge counts only while sequencer_en=1.
- frame_irq pulses on each such edge.
- FRAME_COUNT increments on each such edge, 32-bit, wraps 0xFFFFFFFF->0.
- Simultaneous COMMIT and PROG_DATA in the same cycle are impossible: one address per cycle.
- reset asserted mid-LOAD: everything returns to reset values next cycle. The partial image is discarded; dirty=0, because the sequencer's own reset also zeroes its pointer.

Decomposition:
- Package vga_ctrl_pkg: register index localparams, STATUS bit positions, FSM state enum, UOP_WIDTH.
- One sub-module: the existing sram_1r1w instance for the staging buffer. Everything else inline.

Test Plan:
- Reset, push 3 words (0x11,0x22,0x33), COMMIT from IDLE with run_req=0 -> prog_write_en for exactly 3 consecutive cycles with data 0x11,0x22,0x33; sequencer_en=0 throughout; STATUS reads staged_count=0, busy=0.
- run_req=1 while RUNNING, push 2 words, COMMIT mid-frame -> sequencer_en stays 1 until the next start_frame rise, then 2 writes, then sequencer_en=1 again; FRAME_COUNT +1 per frame start.
- Load without run, then push 1 word and COMMIT -> exactly one sequencer_en=1 cycle (SYNC) precedes the single prog_write_en.
- Push 49 words -> staged_count=48, overflow=1; write STATUS -> overflow=0; push during LOAD -> overflow=1, no extra prog_write_en.
- Clear run_req mid-frame -> sequencer_en falls only after the next start_frame rising edge; frame_irq pulses exactly once at that edge.
- Assert reset on the 2nd LOAD write -> next cycle prog_write_en=0, sequencer_en=0, STATUS=0, FRAME_COUNT=0.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// Shared constants for the VGA sequencer host controller: register map,
// STATUS bit layout, controller FSM states and program word geometry.
package vga_ctrl_pkg;

    // Valid low bits of each sequencer program word
    localparam int UOP_WIDTH = 18;

    // Register word indices on the peripheral bus
    localparam logic [3:0] REG_CTRL        = 4'd0;
    localparam logic [3:0] REG_PROG_DATA   = 4'd1;
    localparam logic [3:0] REG_COMMIT      = 4'd2;
    localparam logic [3:0] REG_STATUS      = 4'd3;
    localparam logic [3:0] REG_FRAME_COUNT = 4'd4;

    // STATUS register layout
    localparam int STATUS_BUSY_BIT     = 0;
    localparam int STATUS_OVERFLOW_BIT = 1;
    localparam int STATUS_SEQ_EN_BIT   = 2;
    localparam int STATUS_PENDING_BIT  = 3;
    localparam int STATUS_COUNT_LSB    = 8;

    // Controller states; the current value is visible as state_q inside the top
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_SYNC    = 3'd3,
        ST_LOAD    = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/sram_1r1w.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module sram_1r1w #(
    parameter int DEPTH  = 48,
    parameter int WIDTH  = 18,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and one-cycle-latency read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vga_sequencer_ctrl.sv
// Host-facing controller for the VGA timing sequencer. Software stages a
// microcode image; on COMMIT the sequencer is stopped at a frame boundary,
// the image is streamed into its instruction memory one word per clock and
// scan-out is re-enabled if run_req is set.
//
// Bus handshake: io_write_en / io_read_en are single-cycle strobes qualified
// by io_address, no back-pressure; io_read_data carries the addressed value
// on the cycle after the io_read_en strobe and reads 0 otherwise.
module vga_sequencer_ctrl #(
    parameter int MAX_INSTRUCTIONS = 48,
    parameter int UOP_WIDTH        = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write_en,
    input  logic        io_read_en,
    input  logic [3:0]  io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    input  logic        start_frame,
    output logic        sequencer_en,
    output logic        prog_write_en,
    output logic [31:0] prog_data,
    output logic        frame_irq
);

    import vga_ctrl_pkg::*;

    localparam int CNT_W  = $clog2(MAX_INSTRUCTIONS + 1);
    localparam int ADDR_W = $clog2(MAX_INSTRUCTIONS);

    ctrl_state_e state_q, state_d;

    logic             run_req_q;
    logic             overflow_q;
    logic             commit_pending_q;
    logic             dirty_q;
    logic [CNT_W-1:0] staged_count_q;
    logic [CNT_W-1:0] load_idx_q;
    logic [31:0]      frame_count_q;
    logic             start_frame_q;
    logic             prog_we_q;
    logic [31:0]      read_data_q;
    logic [31:0]      status_word;
    logic [UOP_WIDTH-1:0] sram_rdata;

    logic wr_ctrl, wr_prog, wr_commit, wr_status;
    logic commit_ok, frame_edge, load_active, load_done, push_blocked, push_ok;
    logic unused_wdata_bits;

    assign wr_ctrl   = io_write_en && (io_address == REG_CTRL);
    assign wr_prog   = io_write_en && (io_address == REG_PROG_DATA);
    assign wr_commit = io_write_en && (io_address == REG_COMMIT);
    assign wr_status = io_write_en && (io_address == REG_STATUS);

    // An empty image or a repeated COMMIT while one is outstanding is ignored
    assign commit_ok   = wr_commit && (staged_count_q != '0) && !commit_pending_q;
    // Frame starts only count while the sequencer is actually enabled
    assign frame_edge  = start_frame && !start_frame_q && sequencer_en;
    assign load_active = (state_q == ST_LOAD) && (load_idx_q < staged_count_q);
    assign load_done   = (state_q == ST_LOAD) && (load_idx_q == staged_count_q);
    // The staging buffer is frozen while an upload is in flight
    assign push_blocked = (state_q inside {ST_LOAD, ST_DRAIN, ST_SYNC}) ||
                          (staged_count_q == CNT_W'(MAX_INSTRUCTIONS));
    assign push_ok      = wr_prog && !push_blocked;

    assign unused_wdata_bits = ^io_write_data[31:UOP_WIDTH];

    sram_1r1w #(
        .DEPTH  (MAX_INSTRUCTIONS),
        .WIDTH  (UOP_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_staging (
        .clk   (clk),
        .we    (push_ok),
        .waddr (staged_count_q[ADDR_W-1:0]),
        .wdata (io_write_data[UOP_WIDTH-1:0]),
        .re    (load_active),
        .raddr (load_idx_q[ADDR_W-1:0]),
        .rdata (sram_rdata)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_ok) begin
                    state_d = dirty_q ? ST_SYNC : ST_LOAD;
                end else if (run_req_q) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (commit_ok) begin
                    state_d = ST_DRAIN;
                end else if (!run_req_q && frame_edge) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (frame_edge) begin
                    state_d = ST_LOAD;
                end
            end
            ST_SYNC: state_d = ST_LOAD;
            ST_LOAD: begin
                if (load_done) begin
                    state_d = run_req_q ? ST_RUNNING : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the sequencer runs in RUNNING/DRAIN and for the single SYNC cycle
    always_comb begin
        sequencer_en = 1'b0;
        if (state_q inside {ST_RUNNING, ST_DRAIN, ST_SYNC}) begin
            sequencer_en = 1'b1;
        end
    end

    // Host-visible control state, staging counters and upload sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            run_req_q        <= 1'b0;
            overflow_q       <= 1'b0;
            commit_pending_q <= 1'b0;
            dirty_q          <= 1'b0;
            staged_count_q   <= '0;
            load_idx_q       <= '0;
            prog_we_q        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                run_req_q <= io_write_data[0];
            end
            if (wr_prog && push_blocked) begin
                overflow_q <= 1'b1;
            end else if (wr_status) begin
                overflow_q <= 1'b0;
            end
            if (load_done) begin
                staged_count_q <= '0;
            end else if (push_ok) begin
                staged_count_q <= staged_count_q + CNT_W'(1);
            end
            if (load_done) begin
                commit_pending_q <= 1'b0;
            end else if (commit_ok) begin
                commit_pending_q <= 1'b1;
            end
            // dirty: the sequencer holds a loaded image but its load pointer was not rezeroed by running
            if (state_q == ST_RUNNING) begin
                dirty_q <= 1'b0;
            end else if (load_done && !run_req_q) begin
                dirty_q <= 1'b1;
            end
            if (state_q != ST_LOAD) begin
                load_idx_q <= '0;
            end else if (load_active) begin
                load_idx_q <= load_idx_q + CNT_W'(1);
            end
            // Word read at cycle k is presented to the sequencer on cycle k+1
            prog_we_q <= load_active;
        end
    end

    // Frame start detection and frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            start_frame_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            start_frame_q <= start_frame;
            if (frame_edge) begin
                frame_count_q <= frame_count_q + 32'd1;
            end
        end
    end

    // STATUS word assembly
    always_comb begin
        status_word = '0;
        status_word[STATUS_BUSY_BIT]     = !(state_q inside {ST_IDLE, ST_RUNNING});
        status_word[STATUS_OVERFLOW_BIT] = overflow_q;
        status_word[STATUS_SEQ_EN_BIT]   = sequencer_en;
        status_word[STATUS_PENDING_BIT]  = commit_pending_q;
        status_word[STATUS_COUNT_LSB +: CNT_W] = staged_count_q;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q <= '0;
        end else if (io_read_en) begin
            case (io_address)
                REG_CTRL:        read_data_q <= {31'd0, run_req_q};
                REG_STATUS:      read_data_q <= status_word;
                REG_FRAME_COUNT: read_data_q <= frame_count_q;
                default:         read_data_q <= '0;
            endcase
        end else begin
            read_data_q <= '0;
        end
    end

    assign io_read_data  = read_data_q;
    assign prog_write_en = prog_we_q;
    assign prog_data     = prog_we_q ? {{(32-UOP_WIDTH){1'b0}}, sram_rdata} : 32'd0;
    assign frame_irq     = frame_edge;

endmodule

// File: tb/tb_vga_sequencer_ctrl.sv
// Self-checking bench for vga_sequencer_ctrl.
module tb_vga_sequencer_ctrl;

  localparam int          MAX_W    = 48;
  localparam logic [31:0] UOP_MASK = 32'h0003_FFFF;
  localparam logic [3:0]  A_CTRL   = 4'd0;
  localparam logic [3:0]  A_PROG   = 4'd1;
  localparam logic [3:0]  A_COMMIT = 4'd2;
  localparam logic [3:0]  A_STATUS = 4'd3;
  localparam logic [3:0]  A_FCNT   = 4'd4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  logic [3:0]  io_address = '0;
  logic [31:0] io_write_data = '0;
  logic [31:0] io_read_data;
  logic        start_frame = 1'b0;
  logic        sequencer_en;
  logic        prog_write_en;
  logic [31:0] prog_data;
  logic        frame_irq;

  always #5 clk = ~clk;

  vga_sequencer_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .start_frame   (start_frame),
    .sequencer_en  (sequencer_en),
    .prog_write_en (prog_write_en),
    .prog_data     (prog_data),
    .frame_irq     (frame_irq)
  );

  // ---------------- output monitor (samples at negedge) ----------------
  int          cyc = 0;
  logic [31:0] got_q[$];
  int          we_cyc_q[$];
  int          en_cnt = 0;
  int          last_en_cyc = -1;
  int          irq_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (prog_write_en) begin
      got_q.push_back(prog_data);
      we_cyc_q.push_back(cyc);
    end
    if (sequencer_en) begin
      en_cnt++;
      last_en_cyc = cyc;
    end
    if (frame_irq) irq_cnt++;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] m_staged[$];
  logic [31:0] exp_q[$];
  bit          m_ovf;
  bit          m_run;
  bit          m_dirty;
  logic [31:0] m_frames;
  int          tests_run = 0;
  int          fails = 0;

  function automatic logic [31:0] exp_status(input bit seq_en);
    logic [31:0] s;
    s = '0;
    s[1] = m_ovf;
    s[2] = seq_en;
    s[13:8] = 6'(m_staged.size());
    return s;
  endfunction

  task automatic model_reset();
    m_staged.delete();
    exp_q.delete();
    m_ovf = 0;
    m_run = 0;
    m_dirty = 0;
    m_frames = '0;
  endtask

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    io_write_en = 1'b1;
    io_address = a;
    io_write_data = d;
    @(posedge clk); #1;
    io_write_en = 1'b0;
    io_write_data = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    io_read_en = 1'b1;
    io_address = a;
    @(posedge clk); #1;
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit upload_busy);
    bus_write(A_PROG, w);
    if (upload_busy || m_staged.size() == MAX_W) m_ovf = 1;
    else m_staged.push_back(w & UOP_MASK);
  endtask

  task automatic commit();
    exp_q.delete();
    foreach (m_staged[i]) exp_q.push_back(m_staged[i]);
    bus_write(A_COMMIT, $urandom);
  endtask

  task automatic wait_writes(input int target, output bit timed_out);
    int k;
    k = 0;
    while (got_q.size() < target && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    timed_out = (got_q.size() < target);
  endtask

  task automatic frame_pulse();
    start_frame = 1'b1;
    @(posedge clk); #1;
    start_frame = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    model_reset();
    tests_run++;
    if ({sequencer_en, prog_write_en, frame_irq} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: got en/we/irq=%b required 000", {sequencer_en, prog_write_en, frame_irq});
    end
    tests_run++;
    if (prog_data !== 32'd0 || io_read_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_data: got prog_data=%h read_data=%h required 0", prog_data, io_read_data);
    end
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_status: got %h required 0", rd); end
    bus_read(A_FCNT, rd);
    tests_run++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_frame_count: got %h required 0", rd); end
    bus_read(A_CTRL, rd);
    tests_run++;
    if (rd !== 32'd0) begin fails++; $display("FAIL reset_ctrl: got %h required 0", rd); end
  endtask

  task automatic test_load_idle();
    logic [31:0] rd;
    int base, en0;
    bit to;
    push_word(32'h11, 0);
    push_word(32'h22, 0);
    push_word(32'h33, 0);
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== exp_status(0)) begin fails++; $display("FAIL idle_staged_status: got %h required %h", rd, exp_status(0)); end
    base = got_q.size();
    en0 = en_cnt;
    commit();
    wait_writes(base + 3, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL idle_load_timeout: got %0d writes required 3", got_q.size() - base); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[base+i] !== exp_q[i]) begin fails++; $display("FAIL idle_load_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]); end
      end
      tests_run++;
      if (we_cyc_q[base+2] - we_cyc_q[base] !== 2) begin fails++; $display("FAIL idle_load_contiguous: got span %0d required 2", we_cyc_q[base+2] - we_cyc_q[base]); end
    end
    idle(2);
    tests_run++;
    if (got_q.size() !== base + 3) begin fails++; $display("FAIL idle_load_count: got %0d required 3", got_q.size() - base); end
    tests_run++;
    if (en_cnt - en0 !== 0) begin fails++; $display("FAIL idle_load_seq_en: got %0d high cycles required 0", en_cnt - en0); end
    m_staged.delete();
    m_dirty = 1;
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== exp_status(0)) begin fails++; $display("FAIL idle_after_status: got %h required %h", rd, exp_status(0)); end
  endtask

  task automatic test_sync();
    int base, en0;
    bit to;
    push_word($urandom, 0);
    base = got_q.size();
    en0 = en_cnt;
    commit();
    wait_writes(base + 1, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL sync_timeout: got %0d writes required 1", got_q.size() - base); end
    else begin
      tests_run++;
      if (got_q[base] !== exp_q[0]) begin fails++; $display("FAIL sync_word: got %h required %h", got_q[base], exp_q[0]); end
      tests_run++;
      if (last_en_cyc >= we_cyc_q[base]) begin fails++; $display("FAIL sync_order: got en cycle %0d required before %0d", last_en_cyc, we_cyc_q[base]); end
    end
    tests_run++;
    if (en_cnt - en0 !== 1) begin fails++; $display("FAIL sync_en_cycles: got %0d required 1", en_cnt - en0); end
    m_staged.delete();
    m_dirty = 1;
  endtask

  task automatic test_running_commit();
    logic [31:0] rd;
    int base, irq0;
    bit to;
    irq0 = irq_cnt;
    bus_write(A_CTRL, 32'd1);
    m_run = 1;
    idle(2);
    m_dirty = 0;
    tests_run++;
    if (sequencer_en !== 1'b1) begin fails++; $display("FAIL run_start_en: got %b required 1", sequencer_en); end
    frame_pulse();
    m_frames++;
    idle(2);
    push_word($urandom, 0);
    push_word($urandom, 0);
    base = got_q.size();
    commit();
    idle(5);
    tests_run++;
    if (sequencer_en !== 1'b1 || got_q.size() !== base) begin
      fails++;
      $display("FAIL drain_hold: got en=%b writes=%0d required en=1 writes=0", sequencer_en, got_q.size() - base);
    end
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== (exp_status(1) | 32'h9)) begin fails++; $display("FAIL drain_status: got %h required %h", rd, exp_status(1) | 32'h9); end
    frame_pulse();
    m_frames++;
    tests_run++;
    if (sequencer_en !== 1'b0) begin fails++; $display("FAIL drain_stop_en: got %b required 0", sequencer_en); end
    wait_writes(base + 2, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL run_load_timeout: got %0d writes required 2", got_q.size() - base); end
    else begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (got_q[base+i] !== exp_q[i]) begin fails++; $display("FAIL run_load_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]); end
      end
      tests_run++;
      if (we_cyc_q[base+1] - we_cyc_q[base] !== 1) begin fails++; $display("FAIL run_load_contiguous: got span %0d required 1", we_cyc_q[base+1] - we_cyc_q[base]); end
    end
    m_staged.delete();
    tests_run++;
    if (sequencer_en !== 1'b1) begin fails++; $display("FAIL run_resume_en: got %b required 1", sequencer_en); end
    bus_read(A_FCNT, rd);
    tests_run++;
    if (rd !== m_frames) begin fails++; $display("FAIL run_frame_count: got %0d required %0d", rd, m_frames); end
    tests_run++;
    if (irq_cnt - irq0 !== 2) begin fails++; $display("FAIL run_irq_count: got %0d required 2", irq_cnt - irq0); end
  endtask

  task automatic test_stop_run();
    logic [31:0] rd;
    int irq0;
    irq0 = irq_cnt;
    bus_write(A_CTRL, 32'd0);
    m_run = 0;
    idle(4);
    tests_run++;
    if (sequencer_en !== 1'b1) begin fails++; $display("FAIL stop_midframe_en: got %b required 1", sequencer_en); end
    frame_pulse();
    m_frames++;
    tests_run++;
    if (sequencer_en !== 1'b0) begin fails++; $display("FAIL stop_after_edge_en: got %b required 0", sequencer_en); end
    idle(3);
    tests_run++;
    if (sequencer_en !== 1'b0) begin fails++; $display("FAIL stop_stays_off: got %b required 0", sequencer_en); end
    tests_run++;
    if (irq_cnt - irq0 !== 1) begin fails++; $display("FAIL stop_irq_count: got %0d required 1", irq_cnt - irq0); end
    bus_read(A_CTRL, rd);
    tests_run++;
    if (rd !== 32'd0) begin fails++; $display("FAIL stop_ctrl: got %h required 0", rd); end
    bus_read(A_FCNT, rd);
    tests_run++;
    if (rd !== m_frames) begin fails++; $display("FAIL stop_frame_count: got %0d required %0d", rd, m_frames); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int base, en0;
    bit to;
    for (int i = 0; i < MAX_W + 1; i++) push_word($urandom, 0);
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== exp_status(0)) begin fails++; $display("FAIL ovf_full_status: got %h required %h", rd, exp_status(0)); end
    bus_write(A_STATUS, 32'd0);
    m_ovf = 0;
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== exp_status(0)) begin fails++; $display("FAIL ovf_clear_status: got %h required %h", rd, exp_status(0)); end
    base = got_q.size();
    en0 = en_cnt;
    commit();
    push_word($urandom, 1);
    wait_writes(base + MAX_W, to);
    tests_run++;
    if (to) begin fails++; $display("FAIL ovf_load_timeout: got %0d writes required %0d", got_q.size() - base, MAX_W); end
    else begin
      for (int i = 0; i < MAX_W; i++) begin
        tests_run++;
        if (got_q[base+i] !== exp_q[i]) begin fails++; $display("FAIL ovf_load_word%0d: got %h required %h", i, got_q[base+i], exp_q[i]); end
      end
    end
    idle(3);
    tests_run++;
    if (got_q.size() !== base + MAX_W) begin fails++; $display("FAIL ovf_extra_writes: got %0d required %0d", got_q.size() - base, MAX_W); end
    tests_run++;
    if (en_cnt - en0 !== 0) begin fails++; $display("FAIL ovf_seq_en: got %0d high cycles required 0", en_cnt - en0); end
    m_staged.delete();
    m_dirty = 1;
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== exp_status(0)) begin fails++; $display("FAIL ovf_load_push_status: got %h required %h", rd, exp_status(0)); end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] rd;
    int base, en0, wc, k;
    bit to;
    bus_write(A_STATUS, 32'd0);
    m_ovf = 0;
    for (int i = 0; i < 4; i++) push_word($urandom, 0);
    commit();
    wc = 0;
    k = 0;
    while (wc < 2 && k < 50) begin
      @(posedge clk); #1;
      if (prog_write_en) wc++;
      k++;
    end
    tests_run++;
    if (wc < 2) begin fails++; $display("FAIL rst_load_timeout: got %0d writes required 2", wc); end
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({sequencer_en, prog_write_en, frame_irq} !== 3'b000) begin
      fails++;
      $display("FAIL rst_load_outputs: got en/we/irq=%b required 000", {sequencer_en, prog_write_en, frame_irq});
    end
    reset = 1'b0;
    model_reset();
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'd0) begin fails++; $display("FAIL rst_load_status: got %h required 0", rd); end
    bus_read(A_FCNT, rd);
    tests_run++;
    if (rd !== 32'd0) begin fails++; $display("FAIL rst_load_frame_count: got %h required 0", rd); end
    push_word($urandom, 0);
    base = got_q.size();
    en0 = en_cnt;
    commit();
    wait_writes(base + 1, to);
    tests_run++;
    if (to || got_q[base] !== exp_q[0]) begin
      fails++;
      $display("FAIL rst_reload_word: got %h required %h", (to ? 32'hDEAD : got_q[base]), exp_q[0]);
    end
    tests_run++;
    if (en_cnt - en0 !== 0) begin fails++; $display("FAIL rst_reload_no_sync: got %0d high cycles required 0", en_cnt - en0); end
    m_staged.delete();
    m_dirty = 1;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int base, en0, n;
    bit rr, exp_sync, to;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      rr = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) push_word($urandom, 0);
      base = got_q.size();
      en0 = en_cnt;
      exp_sync = m_dirty;
      commit();
      bus_write(A_CTRL, {31'd0, rr});
      m_run = rr;
      wait_writes(base + n, to);
      tests_run++;
      if (to) begin fails++; $display("FAIL rnd%0d_timeout: got %0d writes required %0d", r, got_q.size() - base, n); end
      else begin
        for (int i = 0; i < n; i++) begin
          tests_run++;
          if (got_q[base+i] !== exp_q[i]) begin fails++; $display("FAIL rnd%0d_word%0d: got %h required %h", r, i, got_q[base+i], exp_q[i]); end
        end
        tests_run++;
        if (we_cyc_q[base+n-1] - we_cyc_q[base] !== n - 1) begin fails++; $display("FAIL rnd%0d_contiguous: got span %0d required %0d", r, we_cyc_q[base+n-1] - we_cyc_q[base], n - 1); end
      end
      tests_run++;
      if (en_cnt - en0 !== int'(exp_sync)) begin fails++; $display("FAIL rnd%0d_sync_cycles: got %0d required %0d", r, en_cnt - en0, exp_sync); end
      tests_run++;
      if (sequencer_en !== rr) begin fails++; $display("FAIL rnd%0d_exit_en: got %b required %b", r, sequencer_en, rr); end
      m_staged.delete();
      if (rr) begin
        m_dirty = 0;
        bus_write(A_CTRL, 32'd0);
        m_run = 0;
        frame_pulse();
        m_frames++;
        tests_run++;
        if (sequencer_en !== 1'b0) begin fails++; $display("FAIL rnd%0d_stop_en: got %b required 0", r, sequencer_en); end
      end else begin
        m_dirty = 1;
      end
      bus_read(A_STATUS, rd);
      tests_run++;
      if (rd !== exp_status(0)) begin fails++; $display("FAIL rnd%0d_status: got %h required %h", r, rd, exp_status(0)); end
      bus_read(A_FCNT, rd);
      tests_run++;
      if (rd !== m_frames) begin fails++; $display("FAIL rnd%0d_frame_count: got %0d required %0d", r, rd, m_frames); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_load_idle();
    test_sync();
    test_running_commit();
    test_stop_run();
    test_overflow();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
